// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared constants for the RS-232 command sequencer.
//                Contains the default frame start marker, the error codes
//                reported on err_code_o, and the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Rejection reasons reported on err_code_o
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_ADDR    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

endpackage : rs232_pkg
`default_nettype wire

// File: rtl/rs232_byte_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_byte_timeout
//  Description : Inter-byte idle counter. Clears whenever a byte arrives,
//                counts while enabled and saturates at TIMEOUT_CYCLES-1,
//                where it raises expired_o (qualified by enable_i).
//  Ports       : clock     - system clock
//                resetn    - asynchronous active-low reset
//                clear_i   - restart the count (a byte was received)
//                enable_i  - count while a frame is in progress
//                expired_o - idle limit reached
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1330000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    // Saturating at LAST keeps expired_o asserted rather than wrapping
    // should the owner not react to it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired_o = enable_i && (count_q == LAST);

endmodule : rs232_byte_timeout
`default_nettype wire

// File: rtl/rs232_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_cmd_ctrl
//  Description : Frames 4-byte write commands (sync, addr, data, checksum)
//                from a received byte stream, validates them and applies
//                accepted writes to a bank of 8-bit configuration registers.
//  Ports       : clock, resetn        - clock / async active-low reset
//                rx_data_i, rx_valid_i - received byte and its strobe
//                regs_o                - flattened register bank
//                reg_we_o/addr_o/wdata_o - write report pulse
//                err_o, err_code_o     - reject pulse and held reason
//                busy_o                - frame in progress
//                cmd_count_o           - accepted-command counter
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_cmd_ctrl
    import rs232_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1330000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  reg_we_o,
    output logic [3:0]            reg_addr_o,
    output logic [7:0]            reg_wdata_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic                  busy_o,
    output logic [7:0]            cmd_count_o
);

    logic [1:0] state_q, state_d;
    logic [7:0] addr_q, data_q;
    logic       reg_we_q, reg_we_d;
    logic [3:0] reg_addr_q;
    logic [7:0] reg_wdata_q;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] cmd_count_q;
    logic       busy;
    logic       timeout_expired;

    assign busy = (state_q != ST_IDLE);

    rs232_byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .resetn    (resetn),
        .clear_i   (rx_valid_i),
        .enable_i  (busy),
        .expired_o (timeout_expired)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    // A received byte always takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE)) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (rx_valid_i)           state_d = ST_DATA;
                else if (timeout_expired) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (rx_valid_i)           state_d = ST_CHECK;
                else if (timeout_expired) state_d = ST_IDLE;
            end
            ST_CHECK: begin
                if (rx_valid_i || timeout_expired) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output / decision logic ----------------
    // Range check uses all 8 address bits so aliased indices are rejected.
    always_comb begin
        reg_we_d   = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if ((state_q == ST_CHECK) && rx_valid_i) begin
            if (rx_data_i != (addr_q ^ data_q)) begin
                err_d      = 1'b1;
                err_code_d = ERR_CHK;
            end else if (addr_q >= 8'(NUM_REGS)) begin
                err_d      = 1'b1;
                err_code_d = ERR_ADDR;
            end else begin
                reg_we_d   = 1'b1;
            end
        end else if (busy && !rx_valid_i && timeout_expired) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    // ---------------- frame capture and status registers ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            data_q      <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            cmd_count_q <= '0;
        end else begin
            if (rx_valid_i && (state_q == ST_ADDR)) addr_q <= rx_data_i;
            if (rx_valid_i && (state_q == ST_DATA)) data_q <= rx_data_i;
            reg_we_q   <= reg_we_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            if (reg_we_d) begin
                reg_addr_q  <= addr_q[3:0];
                reg_wdata_q <= data_q;
                cmd_count_q <= cmd_count_q + 8'd1;
            end
        end
    end

    // ---------------- register bank ----------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        logic [7:0] bank_q;
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                bank_q <= '0;
            end else if (reg_we_d && (addr_q == 8'(i))) begin
                bank_q <= data_q;
            end
        end
        assign regs_o[8*i +: 8] = bank_q;
    end

    assign reg_we_o    = reg_we_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign busy_o      = busy;
    assign cmd_count_o = cmd_count_q;

endmodule : rs232_cmd_ctrl
`default_nettype wire

// File: tb/tb_rs232_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_cmd_ctrl
//  Description : Self-checking bench for rs232_cmd_ctrl. Frame stimulus
//                pushes expected write/error events into a queue; a monitor
//                pops and compares each event the DUT reports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_cmd_ctrl;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned TMO      = 100;
    localparam logic [7:0]  SYNC     = 8'hA5;

    logic                  clock = 1'b0;
    logic                  resetn = 1'b0;
    logic [7:0]            rx_data = 8'h00;
    logic                  rx_valid = 1'b0;
    logic [NUM_REGS*8-1:0] regs;
    logic                  reg_we;
    logic [3:0]            reg_addr;
    logic [7:0]            reg_wdata;
    logic                  err;
    logic [1:0]            err_code;
    logic                  busy;
    logic [7:0]            cmd_count;

    rs232_cmd_ctrl #(
        .NUM_REGS       (NUM_REGS),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (SYNC)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .regs_o      (regs),
        .reg_we_o    (reg_we),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .err_o       (err),
        .err_code_o  (err_code),
        .busy_o      (busy),
        .cmd_count_o (cmd_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [3:0] addr;
        logic [7:0] data;
        logic [1:0] code;
        logic [7:0] count;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] m_count = 8'd0;
    logic [1:0] m_code  = 2'd0;

    function automatic logic [NUM_REGS*8-1:0] model_flat();
        logic [NUM_REGS*8-1:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_count = 8'd0;
        m_code  = 2'd0;
    endtask

    // Call at posedge+#1; the byte is consumed on the next edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    // Model step for a checksum byte about to be driven.
    task automatic expect_check(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        exp_t e;
        e.cyc  = cyc + 1;
        e.addr = a[3:0];
        e.data = d;
        if (c != (a ^ d)) begin
            e.is_err = 1'b1;
            m_code   = 2'd1;
        end else if (a >= 8'(NUM_REGS)) begin
            e.is_err = 1'b1;
            m_code   = 2'd2;
        end else begin
            e.is_err = 1'b0;
            m_regs[a[2:0]] = d;
            m_count = m_count + 8'd1;
        end
        e.code  = m_code;
        e.count = m_count;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(SYNC);
        send_byte(a);
        send_byte(d);
        expect_check(a, d, c);
        send_byte(c);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (resetn) begin
            if (reg_we && err) begin
                n_cmp++; n_mis++;
                $display("FAIL we_err_exclusive: we=%0d err=%0d, required not both", reg_we, err);
            end
            if (reg_we || err) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_event @%0d: we=%0d err=%0d code=%0d, required no event",
                             cyc, reg_we, err, err_code);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ((err !== e.is_err) || (reg_we === e.is_err) || (cyc != e.cyc) ||
                        (err_code !== e.code) || (cmd_count !== e.count) ||
                        (!e.is_err && ((reg_addr !== e.addr) || (reg_wdata !== e.data) ||
                                       (regs[8*e.addr +: 8] !== e.data)))) begin
                        n_mis++;
                        $display("FAIL event: got err=%0d cyc=%0d code=%0d cnt=%0d addr=%0d wdata=%h reg=%h; required err=%0d cyc=%0d code=%0d cnt=%0d addr=%0d data=%h",
                                 err, cyc, err_code, cmd_count, reg_addr, reg_wdata, regs[8*e.addr +: 8],
                                 e.is_err, e.cyc, e.code, e.count, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL %s_pending: %0d expected events not seen, required 0", name, sb.size());
            sb.delete();
        end
        n_cmp++;
        if ((regs !== model_flat()) || (cmd_count !== m_count) || (err_code !== m_code) || (busy !== 1'b0)) begin
            n_mis++;
            $display("FAIL %s_state: regs=%h cnt=%0d code=%0d busy=%0d; required regs=%h cnt=%0d code=%0d busy=0",
                     name, regs, cmd_count, err_code, busy, model_flat(), m_count, m_code);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0; rx_valid = 1'b0;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ((regs !== '0) || (reg_we !== 1'b0) || (reg_addr !== 4'd0) || (reg_wdata !== 8'd0) ||
            (err !== 1'b0) || (err_code !== 2'd0) || (busy !== 1'b0) || (cmd_count !== 8'd0)) begin
            n_mis++;
            $display("FAIL reset: regs=%h we=%0d addr=%0d wd=%h err=%0d code=%0d busy=%0d cnt=%0d, required all 0",
                     regs, reg_we, reg_addr, reg_wdata, err, err_code, busy, cmd_count);
        end
        resetn = 1'b1;
    endtask

    task automatic test_valid_write();
        @(posedge clock); #1;
        send_frame(8'h03, 8'h3C, 8'h3F);
        drain("valid_write");
    endtask

    task automatic test_bad_checksum();
        @(posedge clock); #1;
        send_frame(8'h02, 8'h11, 8'h00);
        drain("bad_checksum");
    endtask

    task automatic test_bad_addr();
        @(posedge clock); #1;
        send_frame(8'h08, 8'h55, 8'h5D);
        send_frame(8'h18, 8'h11, 8'h09);
        send_frame(8'h00, 8'hFF, 8'hFF);
        drain("bad_addr");
    endtask

    task automatic test_payload_sync();
        @(posedge clock); #1;
        send_frame(8'hA5, 8'h00, 8'hA5);
        send_frame(8'h06, 8'hA5, 8'hA3);
        drain("payload_sync");
    endtask

    task automatic test_timeout();
        exp_t e;
        @(posedge clock); #1;
        send_byte(SYNC);
        send_byte(8'h01);
        m_code   = 2'd3;
        e.is_err = 1'b1; e.addr = 4'd0; e.data = 8'h00;
        e.code   = m_code; e.count = m_count; e.cyc = cyc + TMO;
        sb.push_back(e);
        repeat (TMO - 1) @(posedge clock);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_mis++;
            $display("FAIL timeout_early: busy=%0d one cycle before expiry, required 1", busy);
        end
        drain("timeout");
        @(posedge clock); #1;
        send_byte(8'h7E);
        send_frame(8'h01, 8'hAA, 8'hAB);
        drain("after_timeout");
    endtask

    task automatic test_coincidence();
        @(posedge clock); #1;
        send_byte(SYNC);
        send_byte(8'h01);
        repeat (TMO - 1) @(posedge clock);
        #1;
        send_byte(8'h5A);
        expect_check(8'h01, 8'h5A, 8'h5B);
        send_byte(8'h5B);
        drain("coincidence");
    endtask

    task automatic test_back_to_back();
        @(posedge clock); #1;
        send_frame(8'h04, 8'h12, 8'h16);
        send_frame(8'h05, 8'h34, 8'h31);
        send_frame(8'h07, 8'h0F, 8'h00);
        drain("back_to_back");
    endtask

    task automatic test_reset_midframe();
        @(posedge clock); #1;
        send_byte(SYNC);
        send_byte(8'h02);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_mis++;
            $display("FAIL midframe_busy: busy=%0d, required 1", busy);
        end
        resetn = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ((regs !== '0) || (busy !== 1'b0) || (err !== 1'b0) || (cmd_count !== 8'd0)) begin
            n_mis++;
            $display("FAIL midframe_reset: regs=%h busy=%0d err=%0d cnt=%0d, required all 0",
                     regs, busy, err, cmd_count);
        end
        resetn = 1'b1;
        @(posedge clock); #1;
        send_frame(8'h02, 8'h77, 8'h75);
        drain("reset_midframe");
    endtask

    task automatic test_wrap();
        resetn = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a, d;
            a = 8'(i % NUM_REGS);
            d = 8'(i * 37 + 5);
            send_frame(a, d, a ^ d);
        end
        drain("wrap");
        n_cmp++;
        if (cmd_count !== 8'd0) begin
            n_mis++;
            $display("FAIL wrap_count: cmd_count=%0d, required 0", cmd_count);
        end
    endtask

    initial begin
        test_reset();
        test_valid_write();
        test_bad_checksum();
        test_bad_addr();
        test_payload_sync();
        test_timeout();
        test_coincidence();
        test_back_to_back();
        test_reset_midframe();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_rs232_cmd_ctrl
`default_nettype wire

// File: doc/rs232_cmd_ctrl.md
Name: rs232_cmd_ctrl

Overview:
Command sequencer that sits downstream of the bare RS-232 receiver, consuming its byte/valid stream.
It frames 4-byte write commands (sync, address, data, checksum) and validates each one.
Accepted commands are applied to an internal bank of 8-bit configuration registers, which drive board-level resources such as LEDs.
Malformed, out-of-range or stalled frames are discarded and reported.

Parameters:
NUM_REGS, 8, number of 8-bit configuration registers (1..16)
TIMEOUT_CYCLES, 1330000, idle clocks allowed between bytes inside a frame (10 ms at 133 MHz)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clock  input  1  system clock
resetn  input  1  reset, asynchronous, active-low
rx_data  input  8  received byte; valid only while rx_valid is high
rx_valid  input  1  one-cycle strobe per received byte
regs  output  NUM_REGS*8  flattened register bank; reg i occupies bits [8i+7:8i]
reg_we  output  1  one-cycle pulse when a register is written
reg_addr  output  4  index of the register written (valid with reg_we)
reg_wdata  output  8  value written (valid with reg_we)
err  output  1  one-cycle pulse when a frame is rejected
err_code  output  2  reason, held until the next err: 1 checksum, 2 bad address, 3 timeout
busy  output  1  high while a frame is in progress (any state other than IDLE)
cmd_count  output  8  accepted-command counter, wraps 255->0

Behaviour:
- Reset values:
  - All outputs are 0 during reset, including regs, err_code, cmd_count, and the FSM (IDLE).
  - Reset mid-frame discards the partial frame with no err pulse.
- Input sampling: a byte is consumed only on a clock edge where rx_valid=1. The block never stalls its input.
- FSM states and transitions:
  - IDLE: on a byte equal to SYNC_BYTE go to ADDR; any other byte is ignored silently.
  - ADDR: latch the byte as addr; go to DATA.
  - DATA: latch the byte as data; go to CHECK.
  - CHECK: compare the byte with addr XOR data, then return to IDLE. Three outcomes:
    - Checksum mismatch: err=1, err_code=1.
    - Checksum matches but addr >= NUM_REGS: err=1, err_code=2.
    - Checksum matches and addr is in range: a write is performed.
- SYNC_BYTE inside ADDR/DATA/CHECK is ordinary payload; there is no resync mid-frame.
- Write timing:
  - reg_we, reg_addr (addr[3:0]), reg_wdata and the updated regs entry all become visible the cycle after the CHECK byte edge, i.e. 1-cycle latency.
  - cmd_count increments on that same edge.
  - reg_we lasts exactly one cycle.
  - Back-to-back frames need no gap: a SYNC byte arriving the cycle after CHECK starts a new frame.
- Timeout:
  - An inter-byte counter clears on every rx_valid and counts while busy.
  - When it reaches TIMEOUT_CYCLES-1 in ADDR, DATA or CHECK, the FSM goes to IDLE and pulses err with err_code=3.
  - If rx_valid and timeout expiry coincide, the byte wins: it is consumed and the counter clears.
  - The counter is frozen in IDLE.
- err and reg_we are mutually exclusive, and each is a one-cycle pulse.
- err_code changes only on an err pulse.
- Widths and arithmetic:
  - Address comparison uses the full 8-bit addr, so addr=0x18 is rejected even though its low bits alias a valid index.
  - The counter width is clog2(TIMEOUT_CYCLES).

Decomposition:
- Shared package rs232_pkg holds:
  - SYNC_BYTE default
  - err_code constants ERR_CHK, ERR_ADDR, ERR_TIMEOUT
  - FSM state encoding (IDLE, ADDR, DATA, CHECK)
- One natural sub-module: rs232_byte_timeout, the clearable/enabled inter-byte counter with an expiry strobe.
  - Parameter: TIMEOUT_CYCLES.
  - Ports: clock, resetn, clear, enable, expired.
- The register bank and FSM stay in rs232_cmd_ctrl.

Test Plan:
- Valid write: bytes A5,03,3C,3F -> one cycle after the 4th byte: reg_we=1, reg_addr=3, reg_wdata=3C, regs[31:24]=3C, cmd_count=1, err=0.
- Bad checksum: A5,02,11,00 -> err=1, err_code=1; regs unchanged; cmd_count unchanged; FSM back in IDLE.
- Bad address (NUM_REGS=8): A5,08,55,5D -> err=1, err_code=2; no reg_we. Then A5,00,FF,FF -> regs[7:0]=FF.
- Timeout (TIMEOUT_CYCLES=100 in bench):
  - A5,01 then silence -> err with err_code=3 exactly 100 cycles after the 01 byte; busy drops.
  - A later 7E,A5,01,AA,AB -> leading 7E is ignored; reg1=AA.
- Coincidence and back-to-back:
  - A byte strobed on the expiry cycle is consumed with no err.
  - Two frames with zero gap -> two reg_we pulses.
- Wrap and reset:
  - 256 valid frames -> cmd_count=0.
  - resetn asserted after A5,02 -> all regs 0, no err; the next full frame is accepted.
